// File: rtl/register_write_arbiter_pkg.sv
// Shared definitions for the register write arbiter: state encoding and the
// round-robin find-first search used to pick the next owner.
package register_write_arbiter_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    OWN  = ST_OWN
  } state_e;

  localparam int RR_MAX_REQ = 32;

  // Returns the first set index scanning ptr, ptr+1, ... mod num_req, or -1.
  function automatic int rr_find_first(input logic [RR_MAX_REQ-1:0] req,
                                       input int num_req, input int ptr);
    int         found;
    logic [4:0] idx;
    found = -1;
    for (int i = 0; i < RR_MAX_REQ; i++) begin
      idx = 5'((ptr + i) % num_req);
      if (i < num_req && found < 0 && req[idx]) found = int'(idx);
    end
    return found;
  endfunction

endpackage

// File: rtl/register_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request at or after ptr.
module rr_pick
  import register_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [PTR_W-1:0]   index,
  output logic               valid
);

  logic [RR_MAX_REQ-1:0] req_ext;
  int                    first;

  always_comb begin
    req_ext               = '0;
    req_ext[NUM_REQ-1:0]  = req;
    first                 = rr_find_first(req_ext, NUM_REQ, int'(ptr));
    valid                 = (first >= 0);
    index                 = '0;
    onehot                = '0;
    if (valid) begin
      index         = PTR_W'(first);
      onehot[index] = 1'b1;
    end
  end

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter sequencing one shared load-enabled register among NUM_REQ
// writers, with each grant bounded to MAX_HOLD write cycles.
module register_write_arbiter
  import register_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         reg_in,
  output logic                     reg_load,
  output logic                     busy
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    own_q, own_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic [WIDTH-1:0]    wdata_arr [NUM_REQ];
  logic [PTR_W-1:0]    next_ptr, sel_ptr, pick_idx;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic                pick_valid, write_en, release_own;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) wdata_arr[k] = wdata[k*WIDTH +: WIDTH];
  end

  always_comb begin
    write_en    = (state_q == OWN) && req[own_q];
    next_ptr    = (own_q == PTR_W'(NUM_REQ - 1)) ? '0 : own_q + 1'b1;
    // A dropped request releases without writing; a full hold releases on its last write.
    release_own = (state_q == OWN) &&
                  (!req[own_q] || hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    sel_ptr     = (state_q == OWN) ? next_ptr : ptr_q;
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (req),
    .ptr    (sel_ptr),
    .onehot (pick_onehot),
    .index  (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    own_d      = own_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = OWN;
          gnt_d      = pick_onehot;
          own_d      = pick_idx;
          hold_cnt_d = '0;
        end
      end
      OWN: begin
        if (release_own) begin
          ptr_d      = next_ptr;
          hold_cnt_d = '0;
          if (pick_valid) begin
            gnt_d = pick_onehot;
            own_d = pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (write_en) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ptr_q      <= '0;
      own_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      own_q      <= own_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign reg_load = write_en;
  assign reg_in   = write_en ? wdata_arr[own_q] : '0;
  assign busy     = (state_q == OWN);

endmodule

// File: tb/tb_register_write_arbiter.sv
// Self-checking bench for register_write_arbiter: directed vector table, corner
// sequences and randomized traffic against a behavioural round-robin model.
module tb_register_write_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int H = 4;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   reg_in;
  logic           reg_load;
  logic           busy;

  int errors = 0;
  int checks = 0;

  int           m_owner, m_ptr, m_loads;
  logic [W-1:0] tgt_q;

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic           load;
    logic [W-1:0]   din;
    logic           busy;
  } vec_t;

  vec_t vecs [8];

  always #5 clock = ~clock;

  register_write_arbiter #(
    .NUM_REQ  (N),
    .WIDTH    (W),
    .MAX_HOLD (H)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .wdata    (wdata),
    .gnt      (gnt),
    .reg_in   (reg_in),
    .reg_load (reg_load),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int find_from(input logic [N-1:0] r, input int p);
    int idx;
    for (int i = 0; i < N; i++) begin
      idx = (p + i) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_loads = 0;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N*W-1:0] d);
    req   = r;
    wdata = d;
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    logic         el;
    logic [W-1:0] ei;
    eg = '0;
    el = 1'b0;
    ei = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      el          = req[m_owner];
      if (el) ei = wdata[m_owner*W +: W];
    end
    chk({tag, ".gnt"},  gnt,      eg);
    chk({tag, ".load"}, reg_load, el);
    chk({tag, ".in"},   reg_in,   ei);
    chk({tag, ".busy"}, busy,     (m_owner >= 0));
  endtask

  // Clock edge: external register captures, model advances, return to the negedge.
  task automatic advance();
    logic         l;
    logic [W-1:0] d;
    bit           rel;
    l = reg_load;
    d = reg_in;
    @(posedge clock);
    if (l) tgt_q = d;
    if (m_owner < 0) begin
      m_owner = find_from(req, m_ptr);
      m_loads = 0;
    end else begin
      rel = 1'b0;
      if (req[m_owner]) begin
        m_loads++;
        if (m_loads == H) rel = 1'b1;
      end else begin
        rel = 1'b1;
      end
      if (rel) begin
        m_ptr   = (m_owner + 1) % N;
        m_loads = 0;
        m_owner = find_from(req, m_ptr);
      end
    end
    @(negedge clock);
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] d, input string tag);
    drive(r, d);
    check_model(tag);
    advance();
  endtask

  initial begin
    logic [N*W-1:0] dtab, d2, rd;
    logic [N-1:0]   erot, rr;
    logic [W-1:0]   saved;

    dtab = 64'h1111_BEEF_3333_4444;
    d2   = 64'hDDDD_CCCC_AAAA_9999;
    vecs[0] = '{4'b0100, dtab, 4'b0000, 1'b0, 16'h0000, 1'b0};
    for (int i = 1; i <= 5; i++) vecs[i] = '{4'b0100, dtab, 4'b0100, 1'b1, 16'hBEEF, 1'b1};
    vecs[6] = '{4'b0000, dtab, 4'b0100, 1'b0, 16'h0000, 1'b1};
    vecs[7] = '{4'b0000, dtab, 4'b0000, 1'b0, 16'h0000, 1'b0};

    // Power-on reset
    reset_n = 1'b0;
    req     = '0;
    wdata   = '0;
    tgt_q   = '0;
    model_reset();
    #1;
    chk("reset.gnt",  gnt,      4'b0000);
    chk("reset.load", reg_load, 1'b0);
    chk("reset.in",   reg_in,   16'h0000);
    chk("reset.busy", busy,     1'b0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // All requesters held: rotation 0,1,2,3,0 with H loads each, no bubbles
    drive(4'b1111, {$urandom, $urandom});
    check_model("rr.lat");
    chk("rr.latency_gnt", gnt, 4'b0000);
    advance();
    for (int i = 0; i < 5 * H; i++) begin
      drive(4'b1111, {$urandom, $urandom});
      check_model("rr");
      erot = '0;
      erot[(i / H) % N] = 1'b1;
      chk("rr.rotate_gnt", gnt, erot);
      chk("rr.no_bubble_load", reg_load, 1'b1);
      advance();
    end

    // Asynchronous reset while requester 0 owns the register
    cycle(4'b0001, 64'h0, "mid");
    drive(4'b0001, 64'h0000_0000_0000_5A5A);
    check_model("mid.own");
    chk("mid.own_gnt", gnt, 4'b0001);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset.gnt",  gnt,      4'b0000);
    chk("async_reset.load", reg_load, 1'b0);
    chk("async_reset.busy", busy,     1'b0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cycle(4'b1111, {$urandom, $urandom}, "post");
    drive(4'b1111, {$urandom, $urandom});
    check_model("post");
    chk("post_reset.first_gnt", gnt, 4'b0001);
    advance();
    cycle(4'b0000, 64'h0, "drain");
    cycle(4'b0000, 64'h0, "drain");

    // Single requester vector table
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].req, vecs[i].wdata);
      chk($sformatf("vec%0d.gnt", i),  gnt,      vecs[i].gnt);
      chk($sformatf("vec%0d.load", i), reg_load, vecs[i].load);
      chk($sformatf("vec%0d.in", i),   reg_in,   vecs[i].din);
      chk($sformatf("vec%0d.busy", i), busy,     vecs[i].busy);
      check_model($sformatf("vec%0d.model", i));
      advance();
    end
    chk("vec.reg_captured", tgt_q, 16'hBEEF);

    // Idle: nothing granted, register holds
    saved = tgt_q;
    for (int i = 0; i < 10; i++) begin
      drive(4'b0000, {$urandom, $urandom});
      check_model("idle");
      chk("idle.gnt",  gnt,      4'b0000);
      chk("idle.load", reg_load, 1'b0);
      chk("idle.busy", busy,     1'b0);
      advance();
    end
    chk("idle.reg_hold", tgt_q, saved);

    // Early drop by owner 1 with requester 3 pending, then wrap after 3
    cycle(4'b0010, d2, "drop0");
    drive(4'b1010, d2);
    check_model("drop1");
    chk("drop.owner1_data", reg_in, 16'hAAAA);
    advance();
    cycle(4'b1010, d2, "drop2");
    drive(4'b1000, d2);
    check_model("drop3");
    chk("drop.no_load", reg_load, 1'b0);
    chk("drop.still_gnt1", gnt, 4'b0010);
    advance();
    drive(4'b1001, d2);
    check_model("drop4");
    chk("drop.next_gnt", gnt, 4'b1000);
    advance();
    for (int i = 0; i < H - 1; i++) cycle(4'b1001, d2, "drop_hold");
    drive(4'b1001, d2);
    check_model("wrap");
    chk("drop.wrap_gnt", gnt, 4'b0001);
    advance();

    // Randomized traffic with persistent requests
    rr = '0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 3) == 0) rr[b] = ~rr[b];
      rd = {$urandom, $urandom};
      drive(rr, rd);
      check_model("rand");
      chk("rand.onehot0", $onehot0(gnt), 1'b1);
      chk("rand.load_implies_gnt", (reg_load && gnt == '0), 1'b0);
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
